// File: rtl/multicycle_alu_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/mem/writeback and drives
// the ALU opcode plus datapath selects; resolves beq from the ALU zero flag.
module multicycle_alu_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_ADDI  = 6'h08,
    parameter logic [5:0] OP_J     = 6'h02
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] Alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        MEMADR  = 4'd3,
        MEMRD   = 4'd4,
        MEMWB   = 4'd5,
        MEMWR   = 4'd6,
        EXEC    = 4'd7,
        ALUWB   = 4'd8,
        BRANCH  = 4'd9,
        JUMP    = 4'd10,
        ADDI_EX = 4'd11,
        ADDI_WB = 4'd12,
        TRAP    = 4'd15
    } state_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state_r;
    state_t nxt;
    ctrl_t  ctrl_r;
    logic   illegal_r;

    function automatic logic funct_known(input logic [5:0] f);
        return (f == 6'h20) || (f == 6'h22) || (f == 6'h24) || (f == 6'h25) || (f == 6'h2A);
    endfunction

    function automatic logic [2:0] funct_alu_op(input logic [5:0] f);
        case (f)
            6'h22:   return ALU_SUB;
            6'h24:   return ALU_AND;
            6'h25:   return ALU_OR;
            6'h2A:   return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic state_t next_state(input state_t s, input logic [5:0] op,
                                          input logic [5:0] f);
        case (s)
            IDLE:    return FETCH;
            FETCH:   return DECODE;
            DECODE: begin
                if (op == OP_LW || op == OP_SW) return MEMADR;
                else if (op == OP_RTYPE)        return EXEC;
                else if (op == OP_BEQ)          return BRANCH;
                else if (op == OP_ADDI)         return ADDI_EX;
                else if (op == OP_J)            return JUMP;
                else                            return TRAP;
            end
            MEMADR:  return (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   return MEMWB;
            EXEC:    return funct_known(f) ? ALUWB : TRAP;
            ADDI_EX: return ADDI_WB;
            MEMWB, MEMWR, ALUWB, BRANCH, JUMP, ADDI_WB: return FETCH;
            TRAP:    return TRAP;
            // Unused encodings fall into the trap rather than wandering.
            default: return TRAP;
        endcase
    endfunction

    function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] f);
        ctrl_t c;
        c        = '0;
        c.alu_op = ALU_ADD;
        case (s)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.pc_write  = 1'b1;
            end
            DECODE:  c.alu_src_b = 2'b11;
            MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEMRD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = funct_alu_op(f);
            end
            ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_SUB;
                c.pc_source = 2'b01;
            end
            JUMP: begin
                c.pc_source = 2'b10;
                c.pc_write  = 1'b1;
            end
            ADDI_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            ADDI_WB: c.reg_write = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    assign nxt = next_state(state_r, opcode, funct);

    // Outputs are registered from the upcoming state, so they line up with state_r.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            ctrl_r    <= decode_ctrl(IDLE, funct);
            illegal_r <= 1'b0;
        end else begin
            state_r   <= nxt;
            ctrl_r    <= decode_ctrl(nxt, funct);
            illegal_r <= illegal_r | (nxt == TRAP);
        end
    end

    assign state      = state_r;
    assign Alu_op     = ctrl_r.alu_op;
    assign alu_src_a  = ctrl_r.alu_src_a;
    assign alu_src_b  = ctrl_r.alu_src_b;
    assign pc_source  = ctrl_r.pc_source;
    assign pc_en      = ctrl_r.pc_write | ((state_r == BRANCH) & zero);
    assign i_or_d     = ctrl_r.i_or_d;
    assign mem_read   = ctrl_r.mem_read;
    assign mem_write  = ctrl_r.mem_write;
    assign ir_write   = ctrl_r.ir_write;
    assign reg_dst    = ctrl_r.reg_dst;
    assign mem_to_reg = ctrl_r.mem_to_reg;
    assign reg_write  = ctrl_r.reg_write;
    assign illegal    = illegal_r;

endmodule
